// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
// conv_sched : layer sequencer (pixel fill -> ctrl -> CIM -> func per window)
// Optional CONV_SCHED_PERF_EN adds the o_stall_cycles counter.  Rev 1.0
// ============================================================================
module conv_sched #(
  parameter int IMG_WIDTH  = 13,
  parameter int KERNEL_DIM = 3,
  localparam int c_cw = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_layer_start,
  input  logic            i_pixel_valid,
  output logic            o_pixel_ready,
  output logic            o_ibuf_we,
  output logic            o_ctrl_start,
  input  logic            i_ctrl_busy,
  input  logic            i_cim_busy,
  output logic            o_func_start,
  input  logic            i_func_busy,
  output logic [c_cw-1:0] o_win_row,
  output logic [c_cw-1:0] o_win_col,
  output logic            o_busy,
  output logic            o_done,
  output logic [31:0]     o_stall_cycles
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_fill  = 3'd1;
  localparam logic [2:0] c_issue = 3'd2;
  localparam logic [2:0] c_ctrl  = 3'd3;
  localparam logic [2:0] c_cim   = 3'd4;
  localparam logic [2:0] c_drain = 3'd5;

  localparam logic [c_cw-1:0] c_last_idx = c_cw'(IMG_WIDTH - 1);
  localparam logic [c_cw-1:0] c_k1       = c_cw'(KERNEL_DIM - 1);

  logic [2:0]      r_state;
  logic [c_cw-1:0] r_in_row;
  logic [c_cw-1:0] r_in_col;
  logic [c_cw-1:0] r_win_row;
  logic [c_cw-1:0] r_win_col;
  logic            r_last;

  logic w_gate;
  logic w_accept;
  logic w_win;
  logic w_col_wrap;
  logic w_last_px;

  // Both CIM and func must be idle before a new ctrl write or a new readout.
  assign w_gate     = !i_cim_busy && !i_func_busy;
  assign w_accept   = (r_state == c_fill) && i_pixel_valid;
  assign w_win      = (r_in_row >= c_k1) && (r_in_col >= c_k1);
  assign w_col_wrap = (r_in_col == c_last_idx);
  assign w_last_px  = w_col_wrap && (r_in_row == c_last_idx);

  assign o_pixel_ready = (r_state == c_fill);
  assign o_ibuf_we     = w_accept;
  assign o_ctrl_start  = (r_state == c_issue) && w_gate;
  assign o_func_start  = (r_state == c_cim) && w_gate;
  assign o_done        = (r_state == c_drain) && !i_func_busy;
  assign o_busy        = (r_state != c_idle);
  assign o_win_row     = r_win_row;
  assign o_win_col     = r_win_col;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_idle;
      r_in_row  <= '0;
      r_in_col  <= '0;
      r_win_row <= '0;
      r_win_col <= '0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (i_layer_start) begin
            r_in_row  <= '0;
            r_in_col  <= '0;
            r_win_row <= '0;
            r_win_col <= '0;
            r_last    <= 1'b0;
            r_state   <= c_fill;
          end
        end
        c_fill: begin
          if (w_accept) begin
            // The final pixel always dispatches, so the row never runs past the image.
            if (w_col_wrap) begin
              r_in_col <= '0;
              if (!w_last_px) r_in_row <= r_in_row + 1'b1;
            end else begin
              r_in_col <= r_in_col + 1'b1;
            end
            if (w_win) begin
              r_win_row <= r_in_row - c_k1;
              r_win_col <= r_in_col - c_k1;
              r_last    <= w_last_px;
              r_state   <= c_issue;
            end
          end
        end
        c_issue: if (w_gate) r_state <= c_ctrl;
        c_ctrl:  if (!i_ctrl_busy) r_state <= c_cim;
        c_cim:   if (w_gate) r_state <= r_last ? c_drain : c_fill;
        c_drain: if (!i_func_busy) r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] r_stall;
  logic        w_stall_cyc;

  assign w_stall_cyc = (r_state == c_issue) || (r_state == c_ctrl) ||
                       (r_state == c_cim)   || (r_state == c_drain) ||
                       ((r_state == c_fill) && !i_pixel_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= 32'd0;
    end else if ((r_state == c_idle) && i_layer_start) begin
      r_stall <= 32'd0;
    end else if (w_stall_cyc && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_sched.sv
`default_nettype none
// tb_conv_sched : directed stimulus with a window/handshake model checked every cycle.
module tb_conv_sched;
  localparam int W  = 4;
  localparam int K  = 3;
  localparam int NW = (W - K + 1) * (W - K + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_layer_start = 1'b0, i_pixel_valid = 1'b0;
  logic i_ctrl_busy = 1'b0, i_cim_busy = 1'b0, i_func_busy = 1'b0;
  logic o_pixel_ready, o_ibuf_we, o_ctrl_start, o_func_start, o_busy, o_done;
  logic [1:0]  o_win_row, o_win_col;
  logic [31:0] o_stall_cycles;

  always #5 clk = ~clk;

  conv_sched #(.IMG_WIDTH(W), .KERNEL_DIM(K)) dut (
    .clk(clk), .rst(rst),
    .i_layer_start(i_layer_start), .i_pixel_valid(i_pixel_valid),
    .o_pixel_ready(o_pixel_ready), .o_ibuf_we(o_ibuf_we),
    .o_ctrl_start(o_ctrl_start), .i_ctrl_busy(i_ctrl_busy), .i_cim_busy(i_cim_busy),
    .o_func_start(o_func_start), .i_func_busy(i_func_busy),
    .o_win_row(o_win_row), .o_win_col(o_win_col),
    .o_busy(o_busy), .o_done(o_done), .o_stall_cycles(o_stall_cycles)
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus knobs
  int vmode = 0;      // 0: valid always high, 1: valid toggles every cycle
  int func_len = 2;

  // Model of the expected scheduler behaviour, in protocol terms
  bit m_busy = 0, m_pend = 0, m_drain = 0, m_last = 0;
  int m_ph = 0;       // 0 ctrl not yet issued, 1 waiting on ctrl, 2 waiting for readout
  int m_pix = 0, m_wr = 0, m_wc = 0;
  logic [31:0] m_stall = 0;

  // DUT event records for the current image
  int cyc = 0, n_we = 0, n_ctrl = 0, n_func = 0, n_done = 0;
  int acc11 = 0, first_acc = 0, first_lat = 0;
  int rec_r[8], rec_c[8];
  bit prev_ctrl = 0, prev_func = 0, prev_done = 0;
  bit seen_ctrl = 0, seen_func = 0;

  always @(negedge clk) begin
    bit e_rdy, e_we, e_ctrl, e_func, e_done;
    int r, c;
    logic [31:0] e_stall;
    cyc++;
    if (!rst) begin
      chk("reset_outputs", {26'd0, o_pixel_ready, o_ibuf_we, o_ctrl_start, o_func_start, o_busy, o_done}, 32'd0);
      chk("reset_win", {28'd0, o_win_row, o_win_col}, 32'd0);
      chk("reset_stall", o_stall_cycles, 32'd0);
      m_busy = 0; m_pend = 0; m_drain = 0; m_last = 0; m_ph = 0; m_pix = 0; m_stall = 0;
      m_wr = 0; m_wc = 0;
      n_we = 0; n_ctrl = 0; n_func = 0; n_done = 0;
      prev_ctrl = 0; prev_func = 0; prev_done = 0; seen_ctrl = 0; seen_func = 0;
    end else begin
      e_rdy  = m_busy && !m_pend && !m_drain;
      e_we   = e_rdy && i_pixel_valid;
      e_ctrl = m_pend && (m_ph == 0) && !i_cim_busy && !i_func_busy;
      e_func = m_pend && (m_ph == 2) && !i_cim_busy && !i_func_busy;
      e_done = m_drain && !i_func_busy;
`ifdef CONV_SCHED_PERF_EN
      e_stall = m_stall;
`else
      e_stall = 32'd0;
`endif
      chk("busy", o_busy, m_busy);
      chk("pixel_ready", o_pixel_ready, e_rdy);
      chk("ibuf_we", o_ibuf_we, e_we);
      chk("ibuf_we_rule", o_ibuf_we, i_pixel_valid & o_pixel_ready);
      chk("ctrl_start", o_ctrl_start, e_ctrl);
      chk("func_start", o_func_start, e_func);
      chk("done", o_done, e_done);
      chk("stall_cycles", o_stall_cycles, e_stall);
      if (m_pend) begin
        chk("win_row", o_win_row, m_wr);
        chk("win_col", o_win_col, m_wc);
      end
      chk("pulse_repeat", (prev_ctrl && o_ctrl_start) || (prev_func && o_func_start) || (prev_done && o_done), 0);
      prev_ctrl = o_ctrl_start; prev_func = o_func_start; prev_done = o_done;
      seen_ctrl = o_ctrl_start; seen_func = o_func_start;

      if (o_ibuf_we) begin
        n_we++;
        if (n_we == 11) acc11 = cyc;
      end
      if (o_ctrl_start) begin
        if (n_ctrl == 0) begin
          first_acc = n_we;
          first_lat = cyc - acc11;
        end
        if (n_ctrl < 8) begin
          rec_r[n_ctrl] = o_win_row;
          rec_c[n_ctrl] = o_win_col;
        end
        n_ctrl++;
      end
      if (o_func_start) n_func++;
      if (o_done) n_done++;

      if (!m_busy) begin
        if (i_layer_start) begin
          m_busy = 1; m_pix = 0; m_stall = 0; m_ph = 0;
          n_we = 0; n_ctrl = 0; n_func = 0; n_done = 0;
        end
      end else begin
        if (!e_we && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (e_we) begin
          r = m_pix / W;
          c = m_pix % W;
          m_pix++;
          if (r >= K - 1 && c >= K - 1) begin
            m_pend = 1; m_ph = 0;
            m_wr = r - K + 1; m_wc = c - K + 1;
            m_last = (m_pix == W * W);
          end
        end
        if (e_ctrl) m_ph = 1;
        else if (m_ph == 1 && !i_ctrl_busy) m_ph = 2;
        if (e_func) begin
          m_pend = 0; m_ph = 0;
          if (m_last) m_drain = 1;
        end
        if (e_done) begin
          m_drain = 0; m_busy = 0;
        end
      end
    end
  end

  // Downstream responders: busy rises the cycle after a start pulse
  initial begin
    int ctrl_left, cim_left, func_left;
    ctrl_left = 0; cim_left = 0; func_left = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        ctrl_left = 0; cim_left = 0; func_left = 0;
      end else begin
        if (cim_left > 0) cim_left--;
        if (seen_ctrl) ctrl_left = 2;
        else if (ctrl_left > 0) begin
          ctrl_left--;
          if (ctrl_left == 0) cim_left = 2;
        end
        if (seen_func) func_left = func_len;
        else if (func_left > 0) func_left--;
      end
      i_ctrl_busy = (ctrl_left != 0);
      i_cim_busy  = (cim_left != 0);
      i_func_busy = (func_left != 0);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    i_pixel_valid = (vmode == 0) ? 1'b1 : ~i_pixel_valid;
  end

  task automatic run_image(input int vm, input int flen, input bit mid_start);
    bit got;
    vmode = vm; func_len = flen; got = 0;
    @(posedge clk); #1 i_layer_start = 1'b1;
    @(posedge clk); #1 i_layer_start = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #2;
      if (mid_start) i_layer_start = (i == 20);
      if (n_done > 0) got = 1;
    end
    i_layer_start = 1'b0;
    chk("image_timeout", got, 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_we"}, n_we, 16);
    chk({tag, "_ctrl"}, n_ctrl, NW);
    chk({tag, "_func"}, n_func, NW);
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_busy_low"}, o_busy, 0);
  endtask

  initial begin
    int exp_r[4], exp_c[4];
    bit got;
    exp_r = '{0, 0, 1, 1};
    exp_c = '{0, 1, 0, 1};
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", {26'd0, o_pixel_ready, o_ibuf_we, o_ctrl_start, o_func_start, o_busy, o_done}, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Continuous pixels, short busys
    run_image(0, 2, 0);
    check_counts("img1");
    chk("first_win_accepts", first_acc, 11);
    chk("first_ctrl_latency", first_lat, 1);
    for (int i = 0; i < 4; i++) begin
      chk("win_order_row", rec_r[i], exp_r[i]);
      chk("win_order_col", rec_c[i], exp_c[i]);
    end

    // Long func busy holds off the next ctrl write
    run_image(0, 10, 0);
    check_counts("img_long_func");

    // Start pulse mid-image must be ignored
    run_image(0, 2, 1);
    check_counts("img_mid_start");

    // Gapped valid exercises the stall accounting
    run_image(1, 3, 0);
    check_counts("img_gapped");
`ifndef CONV_SCHED_PERF_EN
    chk("stall_tied_zero", o_stall_cycles, 0);
`endif

    // Reset while waiting on CIM
    vmode = 0; func_len = 2;
    @(posedge clk); #1 i_layer_start = 1'b1;
    @(posedge clk); #1 i_layer_start = 1'b0;
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(posedge clk); #2;
      if (m_pend && m_ph == 2) got = 1;
    end
    chk("reach_cim", got, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_outputs", {26'd0, o_pixel_ready, o_ibuf_we, o_ctrl_start, o_func_start, o_busy, o_done}, 32'd0);
    chk("async_rst_win", {28'd0, o_win_row, o_win_col}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    run_image(0, 2, 0);
    check_counts("img_after_rst");
    for (int i = 0; i < 4; i++) begin
      chk("rerun_win_row", rec_r[i], exp_r[i]);
      chk("rerun_win_col", rec_c[i], exp_c[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_sched.md
# conv_sched

Layer-level sequencer for one convolution layer. It accepts the raster-ordered pixel stream from the previous layer and broadcasts ibuf write enables. It detects when a full kernel window is resident, then sequences ctrl (CIM write), CIM compute and func (CIM readout) once per output pixel. It sits beside the ibuf/ctrl/func instances in the conv layer and drives their start inputs and the ibuf write enable.

## Interface
- img_width, 13, input image width and height (square image), ≥ kernel_dim
- kernel_dim, 3, kernel dimension N (stride 1, no padding)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- i_layer_start  input  1  begin one image; ignored unless IDLE
- i_pixel_valid  input  1  a pixel (all channels) is presented
- o_pixel_ready  output  1  scheduler accepts a pixel this cycle
- o_ibuf_we  output  1  = i_pixel_valid & o_pixel_ready; broadcast to every ibuf
- o_ctrl_start  output  1  one-cycle start to ctrl
- i_ctrl_busy  input  1  ctrl busy
- i_cim_busy  input  1  CIM busy
- o_func_start  output  1  one-cycle start to func
- i_func_busy  input  1  func busy
- o_win_row, o_win_col  output  $clog2(img_width)  top-left coordinate of the window being dispatched
- o_busy  output  1  state ≠ IDLE
- o_done  output  1  one-cycle pulse: image complete
- o_stall_cycles  output  32  stall counter (see Configuration)

## Operation
- States: IDLE, FILL, ISSUE, CTRL, CIM, DRAIN.
- IDLE: on i_layer_start, clear in_row/in_col/win regs and go to FILL.
- FILL: o_pixel_ready=1. On accept, the pixel is at (in_row,in_col); in_col increments and wraps to 0 at img_width-1, when in_row increments.
  - If in_row ≥ kernel_dim-1 and in_col ≥ kernel_dim-1: latch o_win_row=in_row-kernel_dim+1 and o_win_col=in_col-kernel_dim+1, set last=(in_row==in_col==img_width-1), then go to ISSUE.
  - Otherwise stay in FILL.
- ISSUE: o_pixel_ready=0. o_ctrl_start=1 combinationally when !i_cim_busy && !i_func_busy; the same cycle transitions to CTRL.
- CTRL: wait until !i_ctrl_busy, then go to CIM.
- CIM: o_func_start=1 combinationally when !i_cim_busy && !i_func_busy. Then go to DRAIN if last, else FILL. Func runs concurrently with further FILL.
- DRAIN: wait until !i_func_busy, then o_done=1 for that cycle and go to IDLE.
- Dispatched windows per image = (img_width-kernel_dim+1)², in raster order.
- Downstream contract: ctrl and func assert busy in the cycle after their start pulse and hold it until complete. The CTRL and DRAIN states rely on this.

## Timing
- Reset (rst=0, async): state=IDLE, counters and win regs 0, all outputs 0.
- Latency from the accepted window-completing pixel (cycle t) to o_ctrl_start: cycle t+1 if the gates are clear.
- o_ctrl_start, o_func_start and o_done are never high for two consecutive cycles.
- Pixel wrap: in_col=img_width-1 → 0 with in_row+1. in_row does not advance past img_width-1, because the last pixel always dispatches.
- i_layer_start while busy: ignored; no state change.
- i_pixel_valid outside FILL: not accepted; o_ibuf_we=0.
- Reset asserted mid-image: immediate return to IDLE. A pending start is lost and the upstream must restart the image.
- Width: o_win_row/o_win_col use $clog2(img_width) bits (minimum 1).

## Configuration
- CONV_SCHED_PERF_EN defined: o_stall_cycles counts cycles spent in ISSUE, CTRL, CIM or DRAIN, plus FILL cycles with !i_pixel_valid. It clears on i_layer_start accepted in IDLE, saturates at 2³²-1 and holds its value after o_done.
- Not defined: o_stall_cycles is tied to 0 and no counter logic is synthesised.

## Test plan
- img_width=4, kernel_dim=3, continuous valid, busys respond 1-cycle later for 2 cycles: 16 ibuf writes, 4 o_ctrl_start, 4 o_func_start, windows (0,0),(0,1),(1,0),(1,1), then one o_done and o_busy drops.
- First window: 11 pixels accepted before the first o_ctrl_start (pixel (2,2) is the 11th), pulse one cycle after its accept.
- i_func_busy held high 10 cycles after func start: the next o_ctrl_start is withheld until it drops, and o_pixel_ready stays 0 in ISSUE.
- i_layer_start pulsed mid-image: no effect; window count stays 4.
- rst low during CIM: all outputs 0 asynchronously; after release, i_layer_start re-runs the full image correctly.
- With CONV_SCHED_PERF_EN, valid gapped every other cycle: o_stall_cycles equals the count of idle-valid FILL cycles plus wait-state cycles. Without the macro it reads 0.
